frame_sched: RTL and testbench

- Per-frame sequencer between the FSIN output, the MIPI-to-parallel frame_valid, and the histogram/SPI dump path.
- Issues an FSIN strobe on a programmable period, then arms histogram accumulation for exactly one full frame.
- After the frame, triggers the histogram SPI readout and waits for it to finish.
- Counts completed frames, sensor timeouts and period overruns.
- Runs entirely in the clk_pixel_hs domain.

---
 rtl/frame_sched.sv | 267 ++++++++++++++++++++++++++
 tb/tb_frame_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sched.sv
// -----------------------------------------------------------------------------
// frame_sched -- per-frame sequencer for the camera capture path.
//
// Issues a frame-sync strobe to the sensor on a programmable period, arms the
// histogram for exactly one complete frame (frame_valid rise to fall), then
// kicks the histogram SPI dump and waits for it to report completion.
// Completed frames, sensor timeouts and period overruns are counted.
// Everything runs on clk (clk_pixel_hs); all outputs are registered.
//
// Parameters:
//   FSIN_PERIOD  clk cycles between strobes
//   FSIN_WIDTH   strobe high time in clk cycles (>= 1)
//   FV_TIMEOUT   max cycles to wait for a frame_valid rise after a strobe
//   FCNT_W       width of the completed-frame counter
//
// Ports:
//   clk              pixel clock, rising edge
//   reset            synchronous, active-high
//   enable           run the sequencer (period timer held at 0 while low)
//   frame_valid      sensor frame valid, already synchronous to clk
//   readout_done_i   one-cycle pulse from the SPI dump when it has finished
//   ext_trig_i       (FRAME_SCHED_EXT_TRIG_EN only) external frame trigger
//   fsin_o           frame sync strobe to the sensor
//   hist_arm_o       histogram accumulates while high
//   readout_start_o  one-cycle pulse starting the SPI dump
//   busy_o           high whenever the sequencer is not idle
//   frame_count_o    completed frames, wraps
//   timeout_o        one-cycle pulse when no frame arrives after a strobe
//   overrun_o        one-cycle pulse when a trigger arrives while busy
//   err_count_o      timeouts plus overruns, saturates at 255
//
// Optional feature, macro FRAME_SCHED_EXT_TRIG_EN:
//   Adds ext_trig_i. A rising edge on it behaves exactly like a period
//   expiry; coinciding with a timer expiry it counts as one event.
// -----------------------------------------------------------------------------
module frame_sched #(
    parameter int FSIN_PERIOD = 3320000,
    parameter int FSIN_WIDTH  = 16,
    parameter int FV_TIMEOUT  = 1000000,
    parameter int FCNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_valid,
    input  logic              readout_done_i,
`ifdef FRAME_SCHED_EXT_TRIG_EN
    input  logic              ext_trig_i,
`endif
    output logic              fsin_o,
    output logic              hist_arm_o,
    output logic              readout_start_o,
    output logic              busy_o,
    output logic [FCNT_W-1:0] frame_count_o,
    output logic              timeout_o,
    output logic              overrun_o,
    output logic [7:0]        err_count_o
);

    // Counter widths, kept at least one bit wide for degenerate parameters.
    localparam int PER_W = (FSIN_PERIOD > 1) ? $clog2(FSIN_PERIOD) : 1;
    localparam int WID_W = (FSIN_WIDTH  > 1) ? $clog2(FSIN_WIDTH)  : 1;
    localparam int TO_W  = (FV_TIMEOUT  > 1) ? $clog2(FV_TIMEOUT)  : 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(FSIN_PERIOD - 1);
    localparam logic [WID_W-1:0] WID_LAST = WID_W'(FSIN_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT_FV,
        ST_CAPTURE,
        ST_READOUT
    } state_t;

    state_t           state;
    logic [PER_W-1:0] per_cnt;
    logic [WID_W-1:0] wid_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             fv_q;

    logic             per_expiry;
    logic             trig;
    logic             fv_rise;
    logic             fv_fall;
    logic             overrun_evt;
    logic             timeout_evt;
    logic [1:0]       err_inc;
    logic [8:0]       err_sum;

    // -------------------------------------------------------------------------
    // Period timer: free-runs 0..FSIN_PERIOD-1 while enabled, parked at 0
    // otherwise, so the first expiry lands a full period after enable.
    // -------------------------------------------------------------------------
    assign per_expiry = enable && (per_cnt == PER_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge value of its neighbours, independent of order.
        if (reset) begin
            per_cnt <= '0;
        end else if (!enable || per_expiry) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame-valid edge detect.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fv_q <= 1'b0;
        end else begin
            fv_q <= frame_valid;
        end
    end

    assign fv_rise = frame_valid & ~fv_q;
    assign fv_fall = ~frame_valid & fv_q;

    // -------------------------------------------------------------------------
    // Trigger source: timer expiry, optionally OR'd with an external edge.
    // An OR keeps coincident sources as a single event.
    // -------------------------------------------------------------------------
`ifdef FRAME_SCHED_EXT_TRIG_EN
    logic ext_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= ext_trig_i;
        end
    end

    // Gated by enable so the external trigger obeys the same run control
    // as the period timer.
    assign trig = per_expiry | (enable & ext_trig_i & ~ext_q);
`else
    assign trig = per_expiry;
`endif

    // -------------------------------------------------------------------------
    // Error events and saturating error accumulation.
    // A trigger seen while busy is an overrun, including the cycle in which
    // READOUT completes. Timeout only applies while actively waiting: a
    // disable or a genuine rise in the same cycle takes precedence.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        overrun_evt = 1'b0;
        timeout_evt = 1'b0;

        if (trig && (state != ST_IDLE)) begin
            overrun_evt = 1'b1;
        end
        if ((state == ST_WAIT_FV) && enable && !fv_rise && (to_cnt == TO_LAST)) begin
            timeout_evt = 1'b1;
        end
    end

    assign err_inc = {1'b0, overrun_evt} + {1'b0, timeout_evt};
    assign err_sum = {1'b0, err_count_o} + {7'd0, err_inc};

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            wid_cnt         <= '0;
            to_cnt          <= '0;
            fsin_o          <= 1'b0;
            hist_arm_o      <= 1'b0;
            readout_start_o <= 1'b0;
            busy_o          <= 1'b0;
            frame_count_o   <= '0;
            timeout_o       <= 1'b0;
            overrun_o       <= 1'b0;
            err_count_o     <= '0;
        end else begin
            // Single-cycle pulses default low.
            readout_start_o <= 1'b0;
            timeout_o       <= timeout_evt;
            overrun_o       <= overrun_evt;
            err_count_o     <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];

            unique case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state   <= ST_STROBE;
                        fsin_o  <= 1'b1;
                        busy_o  <= 1'b1;
                        wid_cnt <= '0;
                    end
                end

                ST_STROBE: begin
                    if (!enable) begin
                        state  <= ST_IDLE;
                        fsin_o <= 1'b0;
                        busy_o <= 1'b0;
                    end else if (wid_cnt == WID_LAST) begin
                        state  <= ST_WAIT_FV;
                        fsin_o <= 1'b0;
                        to_cnt <= '0;
                    end else begin
                        wid_cnt <= wid_cnt + 1'b1;
                    end
                end

                // A frame already in flight on entry has fv_q high, so only a
                // fresh low-to-high transition starts the capture.
                ST_WAIT_FV: begin
                    if (!enable) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (fv_rise) begin
                        state      <= ST_CAPTURE;
                        hist_arm_o <= 1'b1;
                    end else if (timeout_evt) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                // Disable abandons the partial frame without starting a dump.
                ST_CAPTURE: begin
                    if (!enable) begin
                        state      <= ST_IDLE;
                        hist_arm_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end else if (fv_fall) begin
                        state           <= ST_READOUT;
                        hist_arm_o      <= 1'b0;
                        readout_start_o <= 1'b1;
                    end
                end

                // Runs to completion regardless of enable so the SPI packet
                // is never truncated. A done pulse coincident with the start
                // pulse belongs to no dump of ours and is ignored.
                ST_READOUT: begin
                    if (readout_done_i && !readout_start_o) begin
                        state         <= ST_IDLE;
                        busy_o        <= 1'b0;
                        frame_count_o <= frame_count_o + 1'b1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    fsin_o     <= 1'b0;
                    hist_arm_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_frame_sched -- directed self-checking bench for frame_sched.
//
// Cycle reference: cyc counts rising edges. Stimulus is applied and outputs
// are observed 1 time unit after edge cyc, so an input set at cyc=n is first
// sampled at edge n+1 and a registered reaction to it is visible at cyc=n+1.
// Enable is raised at cyc=b0; the period counter then reads k at edge b0+k,
// the expiry (count 99) is sampled at edge b0+100 and the strobe is visible
// from b0+100 for 4 cycles. Later expiries follow every 100 edges.
//
// A second instance with a 2-bit frame counter shares all inputs, so the
// counter wrap is exercised within a short run.
// -----------------------------------------------------------------------------
module tb_frame_sched;

    localparam int P = 100;
    localparam int W = 4;
    localparam int T = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic frame_valid = 1'b0;
    logic readout_done_i = 1'b0;
`ifdef FRAME_SCHED_EXT_TRIG_EN
    logic ext_trig_i = 1'b0;
`endif

    logic        fsin_o, hist_arm_o, readout_start_o, busy_o;
    logic        timeout_o, overrun_o;
    logic [15:0] frame_count_o;
    logic [7:0]  err_count_o;

    logic        w_fsin, w_hist, w_rs, w_busy, w_to, w_ov;
    logic [1:0]  w_fcnt;
    logic [7:0]  w_err;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_sched #(
        .FSIN_PERIOD (P),
        .FSIN_WIDTH  (W),
        .FV_TIMEOUT  (T),
        .FCNT_W      (16)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .frame_valid     (frame_valid),
        .readout_done_i  (readout_done_i),
`ifdef FRAME_SCHED_EXT_TRIG_EN
        .ext_trig_i      (ext_trig_i),
`endif
        .fsin_o          (fsin_o),
        .hist_arm_o      (hist_arm_o),
        .readout_start_o (readout_start_o),
        .busy_o          (busy_o),
        .frame_count_o   (frame_count_o),
        .timeout_o       (timeout_o),
        .overrun_o       (overrun_o),
        .err_count_o     (err_count_o)
    );

    frame_sched #(
        .FSIN_PERIOD (P),
        .FSIN_WIDTH  (W),
        .FV_TIMEOUT  (T),
        .FCNT_W      (2)
    ) u_wrap (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .frame_valid     (frame_valid),
        .readout_done_i  (readout_done_i),
`ifdef FRAME_SCHED_EXT_TRIG_EN
        .ext_trig_i      (ext_trig_i),
`endif
        .fsin_o          (w_fsin),
        .hist_arm_o      (w_hist),
        .readout_start_o (w_rs),
        .busy_o          (w_busy),
        .frame_count_o   (w_fcnt),
        .timeout_o       (w_to),
        .overrun_o       (w_ov),
        .err_count_o     (w_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after edge number 'target'.
    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Absolute time guard; the directed sequence needs about 31k cycles.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, c0, d0;
        int exp_err;

        // ---------------- reset state ----------------
        go_to(3);
        check("rst_fsin",    32'(fsin_o), 0);
        check("rst_hist",    32'(hist_arm_o), 0);
        check("rst_rs",      32'(readout_start_o), 0);
        check("rst_busy",    32'(busy_o), 0);
        check("rst_fcnt",    32'(frame_count_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        check("rst_err",     32'(err_count_o), 0);
        reset = 1'b0;

        // ---------------- normal frame ----------------
        go_to(5);
        enable = 1'b1;
        b0 = 5;
        go_to(b0 + 99);
        check("s1_fsin_early", 32'(fsin_o), 0);
        check("s1_busy_idle",  32'(busy_o), 0);
        for (int i = 0; i < W; i++) begin
            go_to(b0 + 100 + i);
            check("s1_fsin_high", 32'(fsin_o), 1);
        end
        check("s1_busy", 32'(busy_o), 1);
        go_to(b0 + 104);
        check("s1_fsin_end", 32'(fsin_o), 0);
        go_to(b0 + 119);
        check("s1_hist_pre", 32'(hist_arm_o), 0);
        frame_valid = 1'b1;
        go_to(b0 + 120);
        check("s1_hist_on", 32'(hist_arm_o), 1);
        go_to(b0 + 160);
        check("s1_hist_hold", 32'(hist_arm_o), 1);
        check("s1_rs_pre",    32'(readout_start_o), 0);
        frame_valid = 1'b0;
        go_to(b0 + 161);
        check("s1_hist_off", 32'(hist_arm_o), 0);
        check("s1_rs_pulse", 32'(readout_start_o), 1);
        go_to(b0 + 162);
        check("s1_rs_end",     32'(readout_start_o), 0);
        check("s1_busy_rdout", 32'(busy_o), 1);
        go_to(b0 + 170);
        readout_done_i = 1'b1;
        go_to(b0 + 171);
        readout_done_i = 1'b0;
        check("s1_fcnt", 32'(frame_count_o), 1);
        check("s1_idle", 32'(busy_o), 0);

        // ---------------- silent sensor: timeout ----------------
        // Strobe b0+200..203, WAIT_FV entered at edge b0+204, timeout 50 later.
        go_to(b0 + 253);
        check("s2_to_pre", 32'(timeout_o), 0);
        go_to(b0 + 254);
        check("s2_to_pulse", 32'(timeout_o), 1);
        check("s2_err",      32'(err_count_o), 1);
        check("s2_idle",     32'(busy_o), 0);
        go_to(b0 + 255);
        check("s2_to_end", 32'(timeout_o), 0);
        go_to(b0 + 299);
        check("s2_fsin_pre", 32'(fsin_o), 0);
        go_to(b0 + 300);
        check("s2_fsin_sched", 32'(fsin_o), 1);

        // ---------------- long readout: overrun ----------------
        go_to(b0 + 309);
        frame_valid = 1'b1;
        go_to(b0 + 320);
        frame_valid = 1'b0;
        go_to(b0 + 321);
        check("s3_rs_pulse", 32'(readout_start_o), 1);
        go_to(b0 + 399);
        check("s3_ov_pre", 32'(overrun_o), 0);
        go_to(b0 + 400);
        check("s3_ov_pulse", 32'(overrun_o), 1);
        check("s3_no_fsin",  32'(fsin_o), 0);
        check("s3_err",      32'(err_count_o), 2);
        check("s3_busy",     32'(busy_o), 1);
        go_to(b0 + 401);
        check("s3_ov_end",   32'(overrun_o), 0);
        check("s3_no_fsin2", 32'(fsin_o), 0);
        go_to(b0 + 470);
        readout_done_i = 1'b1;
        go_to(b0 + 471);
        readout_done_i = 1'b0;
        check("s3_fcnt", 32'(frame_count_o), 2);
        check("s3_idle", 32'(busy_o), 0);
        go_to(b0 + 500);
        check("s3_fsin_resume", 32'(fsin_o), 1);

        // ---------------- frame already valid at strobe end ----------------
        go_to(b0 + 501);
        frame_valid = 1'b1;
        go_to(b0 + 512);
        check("s4_hist_mid",  32'(hist_arm_o), 0);
        check("s4_busy_wait", 32'(busy_o), 1);
        frame_valid = 1'b0;
        go_to(b0 + 520);
        check("s4_hist_low", 32'(hist_arm_o), 0);
        frame_valid = 1'b1;
        go_to(b0 + 521);
        check("s4_hist_rise", 32'(hist_arm_o), 1);

        // ---------------- enable dropped mid-CAPTURE ----------------
        go_to(b0 + 530);
        enable = 1'b0;
        go_to(b0 + 531);
        check("s5_hist_drop", 32'(hist_arm_o), 0);
        check("s5_idle",      32'(busy_o), 0);
        check("s5_no_rs",     32'(readout_start_o), 0);
        go_to(b0 + 535);
        frame_valid = 1'b0;
        go_to(b0 + 536);
        check("s5_no_rs_fall", 32'(readout_start_o), 0);
        check("s5_fcnt",       32'(frame_count_o), 2);

        // ---------------- enable dropped mid-READOUT ----------------
        go_to(b0 + 540);
        enable = 1'b1;
        c0 = b0 + 540;
        go_to(c0 + 100);
        check("s6_fsin", 32'(fsin_o), 1);
        go_to(c0 + 109);
        frame_valid = 1'b1;
        go_to(c0 + 119);
        frame_valid = 1'b0;
        go_to(c0 + 120);
        check("s6_rs_pulse", 32'(readout_start_o), 1);
        // Done coincident with the start pulse must be ignored.
        readout_done_i = 1'b1;
        go_to(c0 + 121);
        readout_done_i = 1'b0;
        check("s6_done_ignored", 32'(busy_o), 1);
        check("s6_fcnt_hold",    32'(frame_count_o), 2);
        go_to(c0 + 125);
        enable = 1'b0;
        go_to(c0 + 140);
        check("s6_busy_held", 32'(busy_o), 1);
        go_to(c0 + 144);
        readout_done_i = 1'b1;
        go_to(c0 + 145);
        readout_done_i = 1'b0;
        check("s6_fcnt", 32'(frame_count_o), 3);
        check("s6_idle", 32'(busy_o), 0);
        check("wrap_pre", 32'(w_fcnt), 3);

        // ---------------- 300 timeouts: error counter saturation ----------------
        go_to(c0 + 150);
        enable = 1'b1;
        d0 = c0 + 150;
        exp_err = 2;
        for (int k = 1; k <= 300; k++) begin
            go_to(d0 + P * k + 54);
            check("s7_timeout", 32'(timeout_o), 1);
            exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
            check("s7_err", 32'(err_count_o), 32'(exp_err));
        end

        // ---------------- frame counter wrap ----------------
        go_to(d0 + 30100);
        check("s8_fsin", 32'(fsin_o), 1);
        go_to(d0 + 30109);
        frame_valid = 1'b1;
        go_to(d0 + 30119);
        frame_valid = 1'b0;
        go_to(d0 + 30123);
        readout_done_i = 1'b1;
        go_to(d0 + 30124);
        readout_done_i = 1'b0;
        check("s8_fcnt",     32'(frame_count_o), 4);
        check("s8_wrap",     32'(w_fcnt), 0);
        check("s8_err_sat",  32'(err_count_o), 255);

        // ---------------- reset mid-operation ----------------
        go_to(d0 + 30200);
        check("s9_fsin", 32'(fsin_o), 1);
        reset = 1'b1;
        go_to(d0 + 30201);
        check("s9_fsin_clr", 32'(fsin_o), 0);
        check("s9_busy_clr", 32'(busy_o), 0);
        check("s9_err_clr",  32'(err_count_o), 0);
        check("s9_fcnt_clr", 32'(frame_count_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
